// File: rtl/prog_loader.sv
// Framed program loader: start byte, length, payload into a 256x8 program memory, then checksum.
// The CPU is released only after the payload checksum matches.
module prog_loader #(
  parameter logic [7:0] LOAD_BASE  = 8'h00,
  parameter logic [7:0] START_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cpu_run,
  output logic       load_err,
  output logic [8:0] loaded_len
);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StDone,
    StError
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic        load_err_q, load_err_d;
  logic [8:0]  loaded_len_q, loaded_len_d;

  logic [7:0]  mem_q [256];
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic        xfer;

  assign in_ready  = (state_q != StDone);
  assign xfer      = in_valid && in_ready;
  assign mem_waddr = LOAD_BASE + idx_q[7:0];

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    load_err_d   = load_err_q;
    loaded_len_d = loaded_len_q;
    mem_we       = 1'b0;
    case (state_q)
      StIdle: begin
        if (xfer && in_data == START_BYTE) state_d = StLen;
      end
      StLen: begin
        if (xfer) begin
          // A length byte of zero encodes a full 256-byte frame.
          len_d   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          idx_d   = 9'd0;
          sum_d   = 8'd0;
          state_d = StData;
        end
      end
      StData: begin
        if (xfer) begin
          mem_we = 1'b1;
          sum_d  = sum_q + in_data;
          idx_d  = idx_q + 9'd1;
          if (idx_q + 9'd1 == len_q) state_d = StCsum;
        end
      end
      StCsum: begin
        if (xfer) begin
          if (in_data == sum_q) begin
            state_d      = StDone;
            loaded_len_d = len_q;
          end else begin
            state_d    = StError;
            load_err_d = 1'b1;
          end
        end
      end
      StDone: begin
      end
      StError: begin
        if (xfer && in_data == START_BYTE) begin
          load_err_d = 1'b0;
          state_d    = StLen;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      len_q        <= 9'd0;
      idx_q        <= 9'd0;
      sum_q        <= 8'd0;
      load_err_q   <= 1'b0;
      loaded_len_q <= 9'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      load_err_q   <= load_err_d;
      loaded_len_q <= loaded_len_d;
    end
  end

  // Program memory survives reset so a partially loaded image is kept.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem_q[mem_waddr] <= in_data;
  end

  assign rd_data    = mem_q[rd_addr];
  assign cpu_run    = (state_q == StDone);
  assign load_err   = load_err_q;
  assign loaded_len = loaded_len_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: instance A at LOAD_BASE 0, instance B at LOAD_BASE 0x10.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a_in_data = 8'h00, b_in_data = 8'h00;
  logic       a_in_valid = 1'b0, b_in_valid = 1'b0;
  logic [7:0] a_rd_addr = 8'h00, b_rd_addr = 8'h00;
  logic       a_in_ready, b_in_ready;
  logic [7:0] a_rd_data, b_rd_data;
  logic       a_cpu_run, b_cpu_run;
  logic       a_load_err, b_load_err;
  logic [8:0] a_loaded_len, b_loaded_len;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prog_loader #(.LOAD_BASE(8'h00), .START_BYTE(8'hA5)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (a_in_data),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .rd_addr    (a_rd_addr),
    .rd_data    (a_rd_data),
    .cpu_run    (a_cpu_run),
    .load_err   (a_load_err),
    .loaded_len (a_loaded_len)
  );

  prog_loader #(.LOAD_BASE(8'h10), .START_BYTE(8'hA5)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (b_in_data),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .rd_addr    (b_rd_addr),
    .rd_data    (b_rd_data),
    .cpu_run    (b_cpu_run),
    .load_err   (b_load_err),
    .loaded_len (b_loaded_len)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_a(input logic [7:0] b);
    @(negedge clk);
    a_in_data  = b;
    a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    @(negedge clk);
    b_in_data  = b;
    b_in_valid = 1'b1;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    a_in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic read_a(input logic [7:0] addr, output logic [7:0] d);
    a_rd_addr = addr;
    #1;
    d = a_rd_data;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_cpu_run !== 1'b0 || a_load_err !== 1'b0 || a_loaded_len !== 9'd0) begin
      failures++;
      $display("FAIL reset: ready=%b run=%b err=%b len=%0d, expected 1 0 0 0",
               a_in_ready, a_cpu_run, a_load_err, a_loaded_len);
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] d;
    logic [7:0] exp_mem [3];
    exp_mem[0] = 8'h10; exp_mem[1] = 8'h20; exp_mem[2] = 8'h30;
    send_a(8'h00); send_a(8'hFF); send_a(8'h5A);
    send_a(8'hA5); send_a(8'h03); send_a(8'h10); send_a(8'h20); send_a(8'h30);
    checks++;
    if (a_cpu_run !== 1'b0) begin
      failures++;
      $display("FAIL basic_run_early: cpu_run=%b expected 0", a_cpu_run);
    end
    send_a(8'h60);
    checks++;
    if (a_cpu_run !== 1'b1 || a_loaded_len !== 9'd3 || a_load_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: run=%b len=%0d err=%b, expected 1 3 0",
               a_cpu_run, a_loaded_len, a_load_err);
    end
    for (int i = 0; i < 3; i++) begin
      read_a(8'(i), d);
      checks++;
      if (d !== exp_mem[i]) begin
        failures++;
        $display("FAIL basic_mem[%0d]: got %h expected %h", i, d, exp_mem[i]);
      end
    end
  endtask

  task automatic test_done_hold();
    logic [7:0] d;
    @(negedge clk);
    a_in_data  = 8'hAB;
    a_in_valid = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_ready: in_ready=%b expected 0", a_in_ready);
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    read_a(8'h00, d);
    checks++;
    if (d !== 8'h10 || a_cpu_run !== 1'b1) begin
      failures++;
      $display("FAIL done_hold: mem0=%h run=%b expected 10 1", d, a_cpu_run);
    end
  endtask

  task automatic test_checksum_error();
    logic [7:0] d;
    do_reset();
    send_a(8'hA5); send_a(8'h02); send_a(8'h01); send_a(8'h02); send_a(8'hFF);
    checks++;
    if (a_load_err !== 1'b1 || a_cpu_run !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL csum_err: err=%b run=%b ready=%b expected 1 0 1",
               a_load_err, a_cpu_run, a_in_ready);
    end
    send_a(8'h33);
    send_a(8'hA5);
    checks++;
    if (a_load_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: load_err=%b expected 0", a_load_err);
    end
    send_a(8'h01); send_a(8'h07); send_a(8'h07);
    read_a(8'h00, d);
    checks++;
    if (a_load_err !== 1'b0 || a_cpu_run !== 1'b1 || d !== 8'h07 || a_loaded_len !== 9'd1) begin
      failures++;
      $display("FAIL retry: err=%b run=%b mem0=%h len=%0d expected 0 1 07 1",
               a_load_err, a_cpu_run, d, a_loaded_len);
    end
    read_a(8'h01, d);
    checks++;
    if (d !== 8'h02) begin
      failures++;
      $display("FAIL retry_mem1: got %h expected 02", d);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] d;
    do_reset();
    send_a(8'hA5); send_a(8'h03);
    a_rd_addr = 8'h00;
    @(negedge clk);
    a_in_data  = 8'h11;
    a_in_valid = 1'b1;
    #1;
    checks++;
    if (a_rd_data !== 8'h07) begin
      failures++;
      $display("FAIL same_cycle_read: got %h expected old 07", a_rd_data);
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    checks++;
    if (a_rd_data !== 8'h11) begin
      failures++;
      $display("FAIL write_visible: got %h expected 11", a_rd_data);
    end
    idle_cycle();
    idle_cycle();
    read_a(8'h01, d);
    checks++;
    if (d !== 8'h02) begin
      failures++;
      $display("FAIL gap_no_write: mem1=%h expected 02", d);
    end
    send_a(8'h22);
    idle_cycle();
    send_a(8'h33);
    idle_cycle();
    send_a(8'h66);
    checks++;
    if (a_cpu_run !== 1'b1 || a_loaded_len !== 9'd3) begin
      failures++;
      $display("FAIL gap_done: run=%b len=%0d expected 1 3", a_cpu_run, a_loaded_len);
    end
    read_a(8'h02, d);
    checks++;
    if (d !== 8'h33) begin
      failures++;
      $display("FAIL gap_mem2: got %h expected 33", d);
    end
  endtask

  task automatic test_reset_mid_data();
    logic [7:0] d0, d1, d2;
    do_reset();
    send_a(8'hA5); send_a(8'h04); send_a(8'hAA); send_a(8'hBB);
    do_reset();
    #1;
    read_a(8'h00, d0);
    read_a(8'h01, d1);
    read_a(8'h02, d2);
    checks++;
    if (a_in_ready !== 1'b1 || a_cpu_run !== 1'b0 || a_load_err !== 1'b0 || a_loaded_len !== 9'd0) begin
      failures++;
      $display("FAIL mid_reset_state: ready=%b run=%b err=%b len=%0d expected 1 0 0 0",
               a_in_ready, a_cpu_run, a_load_err, a_loaded_len);
    end
    checks++;
    if (d0 !== 8'hAA || d1 !== 8'hBB || d2 !== 8'h33) begin
      failures++;
      $display("FAIL mid_reset_mem: got %h %h %h expected aa bb 33", d0, d1, d2);
    end
    // Idle again: a non-start byte must not begin a frame.
    send_a(8'h01); send_a(8'h5C); send_a(8'h5C);
    checks++;
    if (a_cpu_run !== 1'b0) begin
      failures++;
      $display("FAIL idle_discard: cpu_run=%b expected 0", a_cpu_run);
    end
    send_a(8'hA5); send_a(8'h01); send_a(8'h5C); send_a(8'h5C);
    read_a(8'h00, d0);
    checks++;
    if (a_cpu_run !== 1'b1 || d0 !== 8'h5C) begin
      failures++;
      $display("FAIL post_reset_frame: run=%b mem0=%h expected 1 5c", a_cpu_run, d0);
    end
  endtask

  task automatic test_full_wrap();
    int bad = 0;
    do_reset();
    send_b(8'hA5);
    send_b(8'h00);
    for (int i = 0; i < 256; i++) send_b(8'(i));
    checks++;
    if (b_cpu_run !== 1'b0 || b_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL wrap_wait_csum: run=%b ready=%b expected 0 1", b_cpu_run, b_in_ready);
    end
    // Sum of 0..255 is 32640, which is 0x80 mod 256.
    send_b(8'h80);
    checks++;
    if (b_cpu_run !== 1'b1 || b_loaded_len !== 9'd256 || b_load_err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_done: run=%b len=%0d err=%b expected 1 256 0",
               b_cpu_run, b_loaded_len, b_load_err);
    end
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = 8'(i + 16);
      b_rd_addr = a;
      #1;
      if (b_rd_data !== 8'(i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wrap_mem: %0d bytes wrong, expected mem[(0x10+i)%%256]=i everywhere", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_done_hold();
    test_checksum_error();
    test_gaps();
    test_reset_mid_data();
    test_full_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
